usb_fifo_arbiter: RTL and testbench
===================================

USB_FIFO_ARBITER -- requirements
Module: usb_fifo_arbiter

Interface
REQ-001 Parameter BURST_LEN, default 16 (legal 1..255), max payload words per grant.
REQ-002 Clk  input  1  system clock, 40 MHz, all logic on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 src_enable  input  2  per-source enable; bit0 = SCurve data, bit1 = ACQ readout data.
REQ-005 scurve_fifo_empty / acq_fifo_empty  input  1 each  source FIFO empty flags.
REQ-006 scurve_fifo_dout / acq_fifo_dout  input  16 each  source FIFO read data, valid the cycle after rd_en.
REQ-007 scurve_fifo_rd_en / acq_fifo_rd_en  output  1 each  source FIFO read strobes.
REQ-008 usb_data_fifo_full  input  1  programmable-full of USB FIFO; asserted while at most 2 entries free.
REQ-009 usb_data_fifo_wr_din  output  16  word to USB FIFO.
REQ-010 usb_data_fifo_wr_en  output  1  USB FIFO write strobe.
REQ-011 arb_busy  output  1  high in every state except IDLE.
REQ-012 arb_grant  output  2  one-hot current grant, 2'b00 in IDLE.

Function
REQ-013 Source i requests when src_enable[i]=1 and its empty=0.
REQ-014 States: IDLE, HDR, RD, FLUSH, TRL.
REQ-015 IDLE: on a request, latch grant and go to HDR; both requesting -> grant source not served last; after reset source 0 wins first.
REQ-016 HDR: when full=0, write header 16'hA5A0 | src_id (0 or 1) and go to RD; when full=1, hold with wr_en=0.
REQ-017 RD: rd_en of granted source is combinational = (state==RD) & !empty & !full & (cnt < BURST_LEN); other rd_en is 0.
REQ-018 Payload: wr_en and wr_din registered one cycle after each rd_en, wr_din = granted dout; cnt (8 bit) increments per rd_en.
REQ-019 RD exits to FLUSH when cnt reaches BURST_LEN or granted source empty=1; full=1 pauses RD, never exits it.
REQ-020 FLUSH: one cycle; the last in-flight payload word is written; no rd_en.
REQ-021 TRL: when full=0, write trailer {8'hB5, cnt}, record last-served source, clear cnt and grant, return to IDLE.
REQ-022 Every packet carries at least one payload word; no packet starts for an empty or disabled source.
REQ-023 Deasserting src_enable mid-packet has no effect on the current packet; checked only in IDLE.
REQ-024 At most one wr_en per cycle; header, payload and trailer never overlap.
REQ-025 Header-to-first-rd_en latency 1 cycle with full=0; packet length = cnt + 2 words.

Reset
REQ-026 reset_n low asynchronously forces: state IDLE, cnt 0, grant 2'b00, last-served = source 1, wr_en 0, wr_din 16'h0000, both rd_en 0, arb_busy 0.
REQ-027 Reset mid-packet abandons the packet; no trailer is written; the first packet after release begins with a fresh header.

Structure
REQ-028 Shared package holds header base 16'hA5A0, trailer tag 8'hB5, source IDs and state encoding.
REQ-029 Single module; no sub-module required.

Verification
REQ-030 Only SCurve enabled, 5 words in FIFO, full=0 -> A5A0, 5 payload words in order, B505; arb_busy drops after trailer.
REQ-031 Both sources hold 40 words, BURST_LEN=16 -> packets alternate src0,src1,src0,...; trailers B510,B510,B510,B510,B508,B508.
REQ-032 full held high 10 cycles during RD -> rd_en 0 throughout; no word lost or duplicated; count in trailer exact.
REQ-033 Source empties after 3 of 16 words -> FLUSH then trailer B503, return to IDLE.
REQ-034 reset_n pulsed low mid-payload -> all outputs at reset values same cycle; next packet starts with A5A0 header.
REQ-035 src_enable=2'b00 with non-empty FIFOs -> no rd_en, no wr_en, arb_busy 0.

Source files
------------

// File: rtl/usb_fifo_arbiter_pkg.sv
// Shared constants and types for the two-source USB packet arbiter.
// Header/trailer framing words, source identifiers and FSM state encoding.
package usb_fifo_arbiter_pkg;

  localparam logic [15:0] HDR_BASE   = 16'hA5A0;
  localparam logic [7:0]  TRL_TAG    = 8'hB5;
  localparam logic        SRC_SCURVE = 1'b0;
  localparam logic        SRC_ACQ    = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_RD    = 3'd2,
    ST_FLUSH = 3'd3,
    ST_TRL   = 3'd4
  } arb_state_e;

  function automatic logic [1:0] src_onehot(input logic src_id);
    return (src_id == SRC_ACQ) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/usb_fifo_arbiter.sv
// Round-robin arbiter moving bursts from the SCurve / ACQ source FIFOs into the
// USB data FIFO, framing each burst as header, payload words, trailer.
module usb_fifo_arbiter
  import usb_fifo_arbiter_pkg::*;
#(
  parameter int unsigned BURST_LEN = 16
) (
  input  logic        Clk,
  input  logic        reset_n,
  input  logic [1:0]  src_enable,
  input  logic        scurve_fifo_empty,
  input  logic        acq_fifo_empty,
  input  logic [15:0] scurve_fifo_dout,
  input  logic [15:0] acq_fifo_dout,
  output logic        scurve_fifo_rd_en,
  output logic        acq_fifo_rd_en,
  input  logic        usb_data_fifo_full,
  output logic [15:0] usb_data_fifo_wr_din,
  output logic        usb_data_fifo_wr_en,
  output logic        arb_busy,
  output logic [1:0]  arb_grant
);

  localparam logic [7:0] BURST_MAX = 8'(BURST_LEN);

  arb_state_e  r_state;
  logic [7:0]  r_cnt;
  logic        r_src;
  logic [1:0]  r_grant;
  logic        r_last;
  logic        r_rd_pend;
  logic        r_wr_en;
  logic [15:0] r_wr_din;

  logic [1:0]  w_req;
  logic        w_pick_src;
  logic        w_empty_g;
  logic [15:0] w_dout_g;
  logic        w_rd;
  logic [7:0]  w_cnt_next;

  assign w_req      = {src_enable[1] & ~acq_fifo_empty, src_enable[0] & ~scurve_fifo_empty};
  // With both sources pending, the one not served last wins.
  assign w_pick_src = (&w_req) ? ~r_last : w_req[1];

  assign w_empty_g  = (r_src == SRC_ACQ) ? acq_fifo_empty : scurve_fifo_empty;
  assign w_dout_g   = (r_src == SRC_ACQ) ? acq_fifo_dout  : scurve_fifo_dout;
  assign w_rd       = (r_state == ST_RD) & ~w_empty_g & ~usb_data_fifo_full & (r_cnt < BURST_MAX);
  assign w_cnt_next = r_cnt + {7'd0, w_rd};

  assign scurve_fifo_rd_en    = w_rd & (r_src == SRC_SCURVE);
  assign acq_fifo_rd_en       = w_rd & (r_src == SRC_ACQ);
  assign usb_data_fifo_wr_en  = r_wr_en;
  assign usb_data_fifo_wr_din = r_wr_din;
  assign arb_busy             = (r_state != ST_IDLE);
  assign arb_grant            = r_grant;

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 8'd0;
      r_src     <= SRC_SCURVE;
      r_grant   <= 2'b00;
      r_last    <= SRC_ACQ;
      r_rd_pend <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_din  <= 16'h0000;
    end else begin
      // Source data arrives the cycle after rd_en; capture it one edge later.
      r_rd_pend <= w_rd;
      r_wr_en   <= r_rd_pend;
      if (r_rd_pend) r_wr_din <= w_dout_g;

      case (r_state)
        ST_IDLE: begin
          if (|w_req) begin
            r_src   <= w_pick_src;
            r_grant <= src_onehot(w_pick_src);
            r_state <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (!usb_data_fifo_full) begin
            r_wr_en  <= 1'b1;
            r_wr_din <= HDR_BASE | {15'd0, r_src};
            r_state  <= ST_RD;
          end
        end
        ST_RD: begin
          r_cnt <= w_cnt_next;
          if ((w_cnt_next == BURST_MAX) || w_empty_g) r_state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          r_state <= ST_TRL;
        end
        ST_TRL: begin
          if (!usb_data_fifo_full) begin
            r_wr_en  <= 1'b1;
            r_wr_din <= {TRL_TAG, r_cnt};
            r_last   <= r_src;
            r_cnt    <= 8'd0;
            r_grant  <= 2'b00;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_fifo_arbiter.sv
// Scoreboard bench for usb_fifo_arbiter: packet-level reference model feeds an
// expected-word queue, a negedge monitor pops and compares every USB write.
module tb_usb_fifo_arbiter;

  localparam int BL = 16;

  logic        Clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  src_enable = 2'b00;
  logic        usb_full = 1'b0;
  logic        sc_empty, acq_empty;
  logic [15:0] sc_dout = 16'h0, acq_dout = 16'h0;
  logic        sc_rd, acq_rd;
  logic [15:0] wr_din;
  logic        wr_en;
  logic        busy;
  logic [1:0]  grant;

  usb_fifo_arbiter #(.BURST_LEN(BL)) dut (
    .Clk                  (Clk),
    .reset_n              (reset_n),
    .src_enable           (src_enable),
    .scurve_fifo_empty    (sc_empty),
    .acq_fifo_empty       (acq_empty),
    .scurve_fifo_dout     (sc_dout),
    .acq_fifo_dout        (acq_dout),
    .scurve_fifo_rd_en    (sc_rd),
    .acq_fifo_rd_en       (acq_rd),
    .usb_data_fifo_full   (usb_full),
    .usb_data_fifo_wr_din (wr_din),
    .usb_data_fifo_wr_en  (wr_en),
    .arb_busy             (busy),
    .arb_grant            (grant)
  );

  always #5 Clk = ~Clk;

  // Source FIFO models: contents loaded by the stimulus, a bump of gen rewinds them.
  logic [15:0] fdata [2][256];
  int sc_n = 0, acq_n = 0;
  int sc_rp = 0, acq_rp = 0;
  int gen = 0, gen_seen = 0;

  always @(posedge Clk) begin
    if (gen != gen_seen) begin
      gen_seen <= gen;
      sc_rp    <= 0;
      acq_rp   <= 0;
    end else begin
      if (sc_rd) begin
        sc_dout <= fdata[0][sc_rp];
        sc_rp   <= sc_rp + 1;
      end
      if (acq_rd) begin
        acq_dout <= fdata[1][acq_rp];
        acq_rp   <= acq_rp + 1;
      end
    end
  end

  assign sc_empty  = (gen != gen_seen) || (sc_rp  >= sc_n);
  assign acq_empty = (gen != gen_seen) || (acq_rp >= acq_n);

  int n_pass = 0;
  int n_total = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
  endtask

  // Monitor: every USB write must match the next expected word.
  always @(negedge Clk) begin
    if (reset_n && wr_en) begin
      if (exp_q.size() == 0) check("write_with_empty_scoreboard", 32'(exp_q.size() != 0), 32'd1);
      else check("usb_word", {16'd0, wr_din}, {16'd0, exp_q.pop_front()});
    end
  end

  // Packet-level model: alternate on contention, up to BL words per packet.
  task automatic build_expected(input int n0, input int n1, input logic [1:0] en);
    int rem[2];
    int pos[2];
    int last, s, k;
    rem[0] = en[0] ? n0 : 0;
    rem[1] = en[1] ? n1 : 0;
    pos[0] = 0;
    pos[1] = 0;
    last = 1;
    while (rem[0] > 0 || rem[1] > 0) begin
      if (rem[0] > 0 && rem[1] > 0) s = 1 - last;
      else s = (rem[0] > 0) ? 0 : 1;
      k = (rem[s] < BL) ? rem[s] : BL;
      exp_q.push_back(16'hA5A0 | 16'(s));
      for (int i = 0; i < k; i++) exp_q.push_back(fdata[s][pos[s] + i]);
      exp_q.push_back({8'hB5, 8'(k)});
      pos[s] += k;
      rem[s] -= k;
      last = s;
    end
  endtask

  task automatic do_reset();
    @(negedge Clk);
    reset_n = 1'b0;
    src_enable = 2'b00;
    usb_full = 1'b0;
    repeat (2) @(negedge Clk);
    reset_n = 1'b1;
  endtask

  task automatic load(input int n0, input int n1, input logic [1:0] en);
    @(negedge Clk);
    src_enable = 2'b00;
    for (int i = 0; i < 256; i++) begin
      fdata[0][i] = 16'($urandom);
      fdata[1][i] = 16'($urandom);
    end
    sc_n  = n0;
    acq_n = n1;
    gen++;
    build_expected(n0, n1, en);
    @(negedge Clk);
    src_enable = en;
  endtask

  task automatic wait_done(input int budget, input bit rand_full);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge Clk);
      usb_full = rand_full ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (exp_q.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
    end
    usb_full = 1'b0;
    check("done_within_budget", 32'(done), 32'd1);
    repeat (4) @(negedge Clk);
    check("idle_after_packets", {30'd0, busy, wr_en}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"},  32'(wr_en), 32'd0);
    check({tag, "_wr_din"}, 32'(wr_din), 32'd0);
    check({tag, "_rd_en"},  {30'd0, acq_rd, sc_rd}, 32'd0);
    check({tag, "_busy"},   32'(busy), 32'd0);
    check({tag, "_grant"},  32'(grant), 32'd0);
  endtask

  initial begin
    bit seen;
    int n0, n1, start_sz;
    logic [1:0] en;

    // Reset values
    #3;
    check_reset_outputs("reset");
    do_reset();

    // Single source, 5 words
    load(5, 0, 2'b01);
    wait_done(500, 1'b0);

    // Both sources 40 words: alternating bursts 16,16,16,16,8,8
    do_reset();
    load(40, 40, 2'b11);
    wait_done(2000, 1'b0);

    // full held for 10 cycles mid-payload
    do_reset();
    load(30, 0, 2'b01);
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge Clk);
      if (sc_rd) begin
        seen = 1'b1;
        break;
      end
    end
    check("rd_started", 32'(seen), 32'd1);
    repeat (3) @(negedge Clk);
    usb_full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("rd_en_during_full", {30'd0, acq_rd, sc_rd}, 32'd0);
      @(negedge Clk);
    end
    usb_full = 1'b0;
    wait_done(1000, 1'b0);

    // Source empties after 3 words
    do_reset();
    load(3, 0, 2'b01);
    wait_done(500, 1'b0);

    // Sources disabled with data present
    do_reset();
    load(10, 10, 2'b00);
    for (int c = 0; c < 30; c++) begin
      @(negedge Clk);
      check("disabled_quiet", {29'd0, busy, wr_en, sc_rd | acq_rd}, 32'd0);
    end

    // Reset mid-payload, then a fresh packet
    do_reset();
    load(20, 0, 2'b01);
    start_sz = exp_q.size();
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge Clk);
      if (exp_q.size() <= start_sz - 4) begin
        seen = 1'b1;
        break;
      end
    end
    check("payload_started", 32'(seen), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    src_enable = 2'b00;
    repeat (2) @(negedge Clk);
    reset_n = 1'b1;
    load(4, 0, 2'b01);
    wait_done(500, 1'b0);

    // Randomized traffic with random backpressure
    for (int it = 0; it < 6; it++) begin
      do_reset();
      n0 = $urandom_range(0, 50);
      n1 = $urandom_range(1, 50);
      en = 2'($urandom_range(1, 3));
      load(n0, n1, en);
      wait_done(4000, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
